// File: rtl/stream_fifo.sv
// ============================================================================
// stream_fifo -- single-clock streaming FIFO built around a 1-cycle
// registered-read `ram`, with valid/ready handshakes on both sides.
//
// Total capacity is RAM_SIZE + 2 words: RAM_SIZE in the RAM, plus the
// output register and one skid register. The skid register absorbs the
// word that is already in flight from the RAM when the consumer stalls.
//
// Parameters:
//   WORD_SIZE  data width in bits (>= 1)
//   RAM_SIZE   RAM depth in words (>= 2, any value, not only powers of two)
//
// Ports:
//   clock      single clock (RAM write and read clocks are both tied to it)
//   n_rst      asynchronous active-low reset
//   in_data    write data
//   in_valid   producer offers in_data
//   in_ready   FIFO accepts this cycle (driven from registers only)
//   out_data   head word (registered)
//   out_valid  out_data holds a valid word
//   out_ready  consumer takes out_data this cycle
//   overflow   (only with STREAM_FIFO_OVF_EN) sticky flag, set when an
//              offer is made while in_ready is low; cleared only by n_rst
//   count      total words held (RAM + pending read + skid + output)
//
// Build option: define STREAM_FIFO_OVF_EN to add the overflow port.
// ============================================================================

// ----------------------------------------------------------------------------
// ram -- simple dual-port memory, synchronous write, registered read.
// Contents are not reset.
//   wr_clock/wr_en/wr_addr/wr_data  write port
//   rd_clock/rd_en/rd_addr/rd_data  read port (rd_data valid 1 cycle later)
// ----------------------------------------------------------------------------
module ram #(
    parameter int WORD_SIZE = 8,
    parameter int RAM_SIZE  = 512,
    parameter int ADDR_BITW = 9
) (
    input  logic                 wr_clock,
    input  logic                 wr_en,
    input  logic [ADDR_BITW-1:0] wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 rd_clock,
    input  logic                 rd_en,
    input  logic [ADDR_BITW-1:0] rd_addr,
    output logic [WORD_SIZE-1:0] rd_data
);

    logic [WORD_SIZE-1:0] mem_q [RAM_SIZE];

    always_ff @(posedge wr_clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge rd_clock) begin
        if (rd_en) begin
            rd_data <= mem_q[rd_addr];
        end
    end

endmodule

// ----------------------------------------------------------------------------
// stream_fifo top
// ----------------------------------------------------------------------------
module stream_fifo #(
    parameter int WORD_SIZE = 8,
    parameter int RAM_SIZE  = 512
) (
    input  logic                         clock,
    input  logic                         n_rst,
    input  logic [WORD_SIZE-1:0]         in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WORD_SIZE-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
`ifdef STREAM_FIFO_OVF_EN
    output logic                         overflow,
`endif
    output logic [$clog2(RAM_SIZE)+1:0]  count
);

    localparam int ADDR_BITW = $clog2(RAM_SIZE);

    localparam logic [ADDR_BITW:0]   MEM_FULL = (ADDR_BITW+1)'(RAM_SIZE);
    localparam logic [ADDR_BITW-1:0] PTR_LAST = ADDR_BITW'(RAM_SIZE - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_BITW-1:0] wr_ptr_q,     wr_ptr_d;
    logic [ADDR_BITW-1:0] rd_ptr_q,     rd_ptr_d;
    logic [ADDR_BITW:0]   mem_count_q,  mem_count_d;
    logic                 rd_pending_q, rd_pending_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [WORD_SIZE-1:0] skid_data_q,  skid_data_d;
    logic                 out_valid_q,  out_valid_d;
    logic [WORD_SIZE-1:0] out_data_q,   out_data_d;
    logic [ADDR_BITW+1:0] count_q,      count_d;

    logic                 push;
    logic                 pop;
    logic                 issue;
    logic                 slot_free;
    logic [1:0]           occ;
    logic [WORD_SIZE-1:0] rd_data;

    // ------------------------------------------------------------------
    // Handshake and read-issue decisions
    // ------------------------------------------------------------------
    assign in_ready = (mem_count_q < MEM_FULL);
    assign push     = in_valid & in_ready;
    assign pop      = out_valid_q & out_ready;

    // Words already committed downstream of the RAM (output, skid, in flight).
    assign occ = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_pending_q};

    // A new read may be launched only if, after this cycle's pop, at most one
    // downstream slot is occupied, so the returning word always has a home.
    // Written as occ < 2 + pop to stay in unsigned arithmetic.
    assign issue = (mem_count_q != '0) && (occ < (2'd2 + {1'b0, pop}));

    // Output register can take a new word after this edge.
    assign slot_free = ~out_valid_q | pop;

    // ------------------------------------------------------------------
    // Pointer / occupancy next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        mem_count_d  = mem_count_q;
        count_d      = count_q;
        rd_pending_d = issue;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (issue) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        unique case ({push, issue})
            2'b10:   mem_count_d = mem_count_q + 1'b1;
            2'b01:   mem_count_d = mem_count_q - 1'b1;
            default: mem_count_d = mem_count_q;
        endcase

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / skid next-state
    // The skid word is always older than a returning RAM word, so it gets
    // the output register first. The issue rule guarantees that whenever a
    // read returns while the output is held, the skid register is empty.
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (slot_free) begin
            if (skid_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = skid_data_q;
                if (rd_pending_q) begin
                    skid_data_d = rd_data;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (rd_pending_q) begin
                out_valid_d = 1'b1;
                out_data_d  = rd_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (rd_pending_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_count_q  <= '0;
            rd_pending_q <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            count_q      <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_count_q  <= mem_count_d;
            rd_pending_q <= rd_pending_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            count_q      <= count_d;
        end
    end

`ifdef STREAM_FIFO_OVF_EN
    logic overflow_q;

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            overflow_q <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = count_q;

    // ------------------------------------------------------------------
    // Storage. wr_ptr == rd_ptr only when mem_count is 0 (no issue) or
    // RAM_SIZE (no push), so write and read never collide on an address.
    // ------------------------------------------------------------------
    ram #(
        .WORD_SIZE (WORD_SIZE),
        .RAM_SIZE  (RAM_SIZE),
        .ADDR_BITW (ADDR_BITW)
    ) u_ram (
        .wr_clock (clock),
        .wr_en    (push),
        .wr_addr  (wr_ptr_q),
        .wr_data  (in_data),
        .rd_clock (clock),
        .rd_en    (issue),
        .rd_addr  (rd_ptr_q),
        .rd_data  (rd_data)
    );

endmodule
